// File: rtl/grf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//
// Contents:
//   REG_W, DATA_W       register-address and data widths
//   wrReq_t             one register-file write request {regAddr, data, pc}
//   grantSel_t          source selected by the arbiter in a cycle
//   DEF_FIFO_DEPTH      default MDU write-buffer depth
//   DEF_STARVE_LIMIT    default number of cycles the buffer head may wait
package grf_write_arbiter_pkg;

  localparam int REG_W            = 5;
  localparam int DATA_W           = 32;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_STARVE_LIMIT = 3;

  typedef struct packed {
    logic [REG_W-1:0]  regAddr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wrReq_t;

  // Which requester owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    GRANT_NONE   = 2'd0,
    GRANT_WB     = 2'd1,
    GRANT_FIFO   = 2'd2,
    GRANT_BYPASS = 2'd3
  } grantSel_t;

endpackage

// File: rtl/grf_write_arbiter_if.sv
// Bundle of pipeline write-back, MDU, register-file and hazard-query signals
// around the register-file write arbiter.
//
// Handshake rules:
//   - Pipeline write-back has no backpressure: a wbValid cycle is a write,
//     except that the pipeline must keep wbValid low while wbStall=1; a
//     wbValid seen while wbStall=1 is discarded.
//   - MDU: a request transfers in a cycle where mdValid=1 and mdReady=1.
//     mdReady depends only on registered state, never on mdValid.
//
// Signals (slave = arbiter side):
//   wbValid/wbReg/wbData/wbPC          pipeline write request
//   wbStall                             pipeline must not issue this cycle
//   mdValid/mdReady/mdReg/mdData/mdPC   MDU write request
//   writeEnable/writeReg/writeData/PCReg registered register-file write port
//   queryReg/queryPending               hazard lookup
//   fifoCount                           buffer occupancy
//   grantDbg                            source granted in the current cycle
interface grf_write_arbiter_if
  import grf_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) ();

  logic                        wbValid;
  logic [REG_W-1:0]            wbReg;
  logic [DATA_W-1:0]           wbData;
  logic [DATA_W-1:0]           wbPC;
  logic                        wbStall;

  logic                        mdValid;
  logic                        mdReady;
  logic [REG_W-1:0]            mdReg;
  logic [DATA_W-1:0]           mdData;
  logic [DATA_W-1:0]           mdPC;

  logic                        writeEnable;
  logic [REG_W-1:0]            writeReg;
  logic [DATA_W-1:0]           writeData;
  logic [DATA_W-1:0]           PCReg;

  logic [REG_W-1:0]            queryReg;
  logic                        queryPending;

  logic [$clog2(FIFO_DEPTH):0] fifoCount;
  grantSel_t                   grantDbg;

  modport slave (
    input  wbValid, wbReg, wbData, wbPC,
    input  mdValid, mdReg, mdData, mdPC,
    input  queryReg,
    output wbStall, mdReady,
    output writeEnable, writeReg, writeData, PCReg,
    output queryPending, fifoCount, grantDbg
  );

  modport master (
    output wbValid, wbReg, wbData, wbPC,
    output mdValid, mdReg, mdData, mdPC,
    output queryReg,
    input  wbStall, mdReady,
    input  writeEnable, writeReg, writeData, PCReg,
    input  queryPending, fifoCount, grantDbg
  );

endinterface

// File: rtl/grf_wq_fifo.sv
// MDU write buffer: a small FIFO of write requests.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   push         write pushData at the tail (caller guarantees not full)
//   pushData     request to store
//   pop          drop the head entry (caller guarantees not empty)
//   headData     oldest stored request
//   count        occupancy, 0..DEPTH
//   regView      destination register of every slot
//   validView    per-slot valid bit, for the hazard lookup
//
// Pointers wrap modulo DEPTH (power of two); full vs. empty is told apart by
// count alone.
module grf_wq_fifo
  import grf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wrReq_t                 pushData,
  input  logic                   pop,
  output wrReq_t                 headData,
  output logic [$clog2(DEPTH):0] count,
  output logic [REG_W-1:0]       regView [DEPTH],
  output logic [DEPTH-1:0]       validView
);

  localparam int PTR_W = $clog2(DEPTH);

  wrReq_t           mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [DEPTH-1:0] slotValid;

  // Payload storage carries no reset; slotValid says what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      slotValid <= '0;
    end else begin
      // Push and pop never target the same slot: that would need the buffer
      // to be both full (pop allowed) and not full (push allowed).
      if (pop) begin
        slotValid[rdPtr] <= 1'b0;
        rdPtr            <= rdPtr + PTR_W'(1);
      end
      if (push) begin
        slotValid[wrPtr] <= 1'b1;
        wrPtr            <= wrPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign headData  = mem[rdPtr];
  assign validView = slotValid;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regView[i] = mem[i].regAddr;
    end
  end

endmodule

// File: rtl/grf_write_arbiter.sv
// Register-file write arbiter between the pipeline write-back stage and the
// multiply/divide unit (MDU).
//
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   bus    grf_write_arbiter_if.slave (write-back, MDU, register-file write
//          port, hazard query, buffer occupancy, grant debug)
//
// Each cycle exactly one source may own the register-file write port; the
// chosen request is registered so the strobe appears one cycle after the
// grant. MDU results that cannot be written immediately wait in a FIFO whose
// head ages while it is passed over; at STARVE_LIMIT the pipeline is stalled
// for a cycle so the head can drain.
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic               clk,
  input logic               reset,
  grf_write_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  // ---------------- buffer ----------------
  logic              fifoPush;
  logic              fifoPop;
  wrReq_t            fifoHead;
  wrReq_t            mdReq;
  logic [CNT_W-1:0]  fifoCount;
  logic [REG_W-1:0]  entryReg [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] entryValid;

  assign mdReq = '{regAddr: bus.mdReg, data: bus.mdData, pc: bus.mdPC};

  grf_wq_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifoPush),
    .pushData  (mdReq),
    .pop       (fifoPop),
    .headData  (fifoHead),
    .count     (fifoCount),
    .regView   (entryReg),
    .validView (entryValid)
  );

  // ---------------- state ----------------
  logic [AGE_W-1:0]  age;
  logic              writeEnableQ;
  logic [REG_W-1:0]  writeRegQ;
  logic [DATA_W-1:0] writeDataQ;
  logic [DATA_W-1:0] pcQ;

  // ---------------- decode from registered state ----------------
  logic      wbStall;
  logic      mdReady;
  logic      fifoEmpty;
  grantSel_t grantSel;
  wrReq_t    grantReq;

  assign fifoEmpty = (fifoCount == '0);
  // Both are forced low during reset so nothing handshakes on a reset cycle.
  assign wbStall   = !reset && (age == AGE_W'(STARVE_LIMIT));
  assign mdReady   = !reset && (fifoCount < CNT_W'(FIFO_DEPTH));

  // Grant priority: starving head, pipeline, buffered head, MDU bypass.
  // A wbValid during wbStall is a protocol violation and is simply ignored
  // because the stalled branch wins.
  always_comb begin
    grantSel = GRANT_NONE;
    if (!reset) begin
      if (wbStall) begin
        grantSel = GRANT_FIFO;
      end else if (bus.wbValid) begin
        grantSel = GRANT_WB;
      end else if (!fifoEmpty) begin
        grantSel = GRANT_FIFO;
      end else if (bus.mdValid) begin
        grantSel = GRANT_BYPASS;
      end
    end
  end

  always_comb begin
    grantReq = '0;
    case (grantSel)
      GRANT_WB:     grantReq = '{regAddr: bus.wbReg, data: bus.wbData, pc: bus.wbPC};
      GRANT_FIFO:   grantReq = fifoHead;
      GRANT_BYPASS: grantReq = mdReq;
      default:      grantReq = '0;
    endcase
  end

  // An accepted MDU request goes to the buffer unless it was written directly.
  assign fifoPush = bus.mdValid && mdReady && (grantSel != GRANT_BYPASS);
  assign fifoPop  = (grantSel == GRANT_FIFO);

  // ---------------- head-age counter ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      age <= '0;
    end else if (fifoEmpty || fifoPop) begin
      age <= '0;
    end else if (age != AGE_W'(STARVE_LIMIT)) begin
      age <= age + AGE_W'(1);
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      writeEnableQ <= 1'b0;
      writeRegQ    <= '0;
      writeDataQ   <= '0;
      pcQ          <= '0;
    end else begin
      writeEnableQ <= (grantSel != GRANT_NONE);
      writeRegQ    <= grantReq.regAddr;
      writeDataQ   <= grantReq.data;
      pcQ          <= grantReq.pc;
    end
  end

  // ---------------- hazard lookup ----------------
  // A register is pending while its write sits in the buffer or in the output
  // stage; register 0 is never pending since the register file drops it.
  logic queryHit;

  always_comb begin
    queryHit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entryValid[i] && (entryReg[i] == bus.queryReg)) begin
        queryHit = 1'b1;
      end
    end
    if (writeEnableQ && (writeRegQ == bus.queryReg)) begin
      queryHit = 1'b1;
    end
  end

  // ---------------- interface outputs ----------------
  assign bus.wbStall      = wbStall;
  assign bus.mdReady      = mdReady;
  assign bus.writeEnable  = writeEnableQ;
  assign bus.writeReg     = writeRegQ;
  assign bus.writeData    = writeDataQ;
  assign bus.PCReg        = pcQ;
  assign bus.queryPending = (bus.queryReg != '0) && queryHit;
  assign bus.fifoCount    = fifoCount;
  assign bus.grantDbg     = grantSel;

endmodule

// File: tb/tb_grf_write_arbiter.sv
module tb_grf_write_arbiter;
  import grf_write_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  grf_write_arbiter_if #(.FIFO_DEPTH(4)) bus ();

  grf_write_arbiter #(
    .FIFO_DEPTH   (4),
    .STARVE_LIMIT (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] md_data(input int r);
    return 32'hA000_0000 | 32'(r);
  endfunction

  function automatic logic [31:0] wb_data(input int r);
    return 32'hB000_0000 | 32'(r);
  endfunction

  task automatic set_wb(input logic v, input int r);
    bus.wbValid = v;
    bus.wbReg   = 5'(r);
    bus.wbData  = wb_data(r);
    bus.wbPC    = 32'h2000 + 32'(r * 4);
  endtask

  task automatic set_md(input logic v, input int r);
    bus.mdValid = v;
    bus.mdReg   = 5'(r);
    bus.mdData  = md_data(r);
    bus.mdPC    = 32'h1000 + 32'(r * 4);
  endtask

  task automatic drive_idle();
    set_wb(1'b0, 0);
    set_md(1'b0, 0);
    bus.queryReg = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    set_md(1'b1, 8);  // must be ignored while in reset
    tick();
    tick();
    n_cmp++; if (bus.writeEnable !== 1'b0) begin n_err++; $display("FAIL rst_we got=%b exp=0", bus.writeEnable); end
    n_cmp++; if (bus.writeReg !== 5'd0) begin n_err++; $display("FAIL rst_wreg got=%0d exp=0", bus.writeReg); end
    n_cmp++; if (bus.writeData !== 32'd0) begin n_err++; $display("FAIL rst_wdata got=%h exp=0", bus.writeData); end
    n_cmp++; if (bus.fifoCount !== 3'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", bus.fifoCount); end
    n_cmp++; if (bus.mdReady !== 1'b0) begin n_err++; $display("FAIL rst_mdready got=%b exp=0", bus.mdReady); end
    n_cmp++; if (bus.wbStall !== 1'b0) begin n_err++; $display("FAIL rst_wbstall got=%b exp=0", bus.wbStall); end
    drive_idle();
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.mdReady !== 1'b1) begin n_err++; $display("FAIL rst_release_mdready got=%b exp=1", bus.mdReady); end
  endtask

  task automatic test_bypass();
    bus.mdValid = 1'b1;
    bus.mdReg   = 5'd8;
    bus.mdData  = 32'h11;
    bus.mdPC    = 32'h100;
    tick();
    n_cmp++; if (bus.writeEnable !== 1'b1) begin n_err++; $display("FAIL byp_we got=%b exp=1", bus.writeEnable); end
    n_cmp++; if (bus.writeReg !== 5'd8) begin n_err++; $display("FAIL byp_wreg got=%0d exp=8", bus.writeReg); end
    n_cmp++; if (bus.writeData !== 32'h11) begin n_err++; $display("FAIL byp_wdata got=%h exp=11", bus.writeData); end
    n_cmp++; if (bus.PCReg !== 32'h100) begin n_err++; $display("FAIL byp_pc got=%h exp=100", bus.PCReg); end
    n_cmp++; if (bus.fifoCount !== 3'd0) begin n_err++; $display("FAIL byp_count got=%0d exp=0", bus.fifoCount); end
    drive_idle();
    tick();
    n_cmp++; if (bus.writeEnable !== 1'b0) begin n_err++; $display("FAIL byp_idle_we got=%b exp=0", bus.writeEnable); end
  endtask

  task automatic test_fill_full();
    // Pipeline writes regs 1..4 while the MDU pushes 16..19 into the buffer.
    for (int i = 0; i < 4; i++) begin
      set_wb(1'b1, i + 1);
      set_md(1'b1, 16 + i);
      tick();
      n_cmp++; if (bus.writeReg !== 5'(i + 1)) begin n_err++; $display("FAIL fill_wreg[%0d] got=%0d exp=%0d", i, bus.writeReg, i + 1); end
      n_cmp++; if (bus.fifoCount !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus.fifoCount, i + 1); end
    end
    n_cmp++; if (bus.mdReady !== 1'b0) begin n_err++; $display("FAIL full_mdready got=%b exp=0", bus.mdReady); end
    n_cmp++; if (bus.wbStall !== 1'b1) begin n_err++; $display("FAIL full_wbstall got=%b exp=1", bus.wbStall); end
    // Fifth MDU request held; illegal wbValid during the stall is dropped.
    set_wb(1'b1, 5);
    set_md(1'b1, 20);
    tick();
    n_cmp++; if (bus.writeReg !== 5'd16) begin n_err++; $display("FAIL stall_drain_wreg got=%0d exp=16", bus.writeReg); end
    n_cmp++; if (bus.writeData !== md_data(16)) begin n_err++; $display("FAIL stall_drain_wdata got=%h exp=%h", bus.writeData, md_data(16)); end
    n_cmp++; if (bus.fifoCount !== 3'd3) begin n_err++; $display("FAIL stall_drain_count got=%0d exp=3", bus.fifoCount); end
    n_cmp++; if (bus.mdReady !== 1'b1) begin n_err++; $display("FAIL mdready_back got=%b exp=1", bus.mdReady); end
    n_cmp++; if (bus.wbStall !== 1'b0) begin n_err++; $display("FAIL stall_clear got=%b exp=0", bus.wbStall); end
    set_wb(1'b0, 0);
    tick();  // pop 17 and push 20 together
    n_cmp++; if (bus.writeReg !== 5'd17) begin n_err++; $display("FAIL pushpop_wreg got=%0d exp=17", bus.writeReg); end
    n_cmp++; if (bus.fifoCount !== 3'd3) begin n_err++; $display("FAIL pushpop_count got=%0d exp=3", bus.fifoCount); end
    set_md(1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (bus.writeReg !== 5'(18 + k) || bus.writeEnable !== 1'b1) begin n_err++; $display("FAIL drain_wreg[%0d] got=%0d/%b exp=%0d/1", k, bus.writeReg, bus.writeEnable, 18 + k); end
      n_cmp++; if (bus.writeData !== md_data(18 + k)) begin n_err++; $display("FAIL drain_wdata[%0d] got=%h exp=%h", k, bus.writeData, md_data(18 + k)); end
    end
    tick();
    n_cmp++; if (bus.writeEnable !== 1'b0 || bus.fifoCount !== 3'd0) begin n_err++; $display("FAIL drain_done got=%b/%0d exp=0/0", bus.writeEnable, bus.fifoCount); end
  endtask

  task automatic test_starve();
    set_wb(1'b1, 3);
    set_md(1'b1, 9);
    tick();
    set_md(1'b0, 0);
    n_cmp++; if (bus.fifoCount !== 3'd1) begin n_err++; $display("FAIL starve_count got=%0d exp=1", bus.fifoCount); end
    n_cmp++; if (bus.wbStall !== 1'b0) begin n_err++; $display("FAIL starve_age0 got=%b exp=0", bus.wbStall); end
    for (int i = 0; i < 3; i++) begin
      set_wb(1'b1, 4 + i);
      tick();
      n_cmp++; if (bus.writeReg !== 5'(4 + i)) begin n_err++; $display("FAIL starve_wb_wreg[%0d] got=%0d exp=%0d", i, bus.writeReg, 4 + i); end
      n_cmp++; if (bus.wbStall !== (i == 2)) begin n_err++; $display("FAIL starve_stall[%0d] got=%b exp=%b", i, bus.wbStall, (i == 2)); end
    end
    set_wb(1'b0, 0);
    tick();
    n_cmp++; if (bus.writeEnable !== 1'b1 || bus.writeReg !== 5'd9) begin n_err++; $display("FAIL starve_head got=%b/%0d exp=1/9", bus.writeEnable, bus.writeReg); end
    n_cmp++; if (bus.wbStall !== 1'b0 || bus.fifoCount !== 3'd0) begin n_err++; $display("FAIL starve_after got=%b/%0d exp=0/0", bus.wbStall, bus.fifoCount); end
    tick();
  endtask

  task automatic test_push_pop_wrap();
    for (int i = 0; i < 8; i++) begin
      set_wb(i < 2, 30);
      set_md(1'b1, i + 1);
      tick();
      if (i < 2) begin
        n_cmp++; if (bus.fifoCount !== 3'(i + 1) || bus.writeReg !== 5'd30) begin n_err++; $display("FAIL wrap_load[%0d] got=%0d/%0d exp=%0d/30", i, bus.fifoCount, bus.writeReg, i + 1); end
      end else begin
        n_cmp++; if (bus.writeReg !== 5'(i - 1) || bus.fifoCount !== 3'd2) begin n_err++; $display("FAIL wrap_steady[%0d] got=%0d/%0d exp=%0d/2", i, bus.writeReg, bus.fifoCount, i - 1); end
      end
    end
    set_md(1'b0, 0);
    for (int j = 0; j < 2; j++) begin
      tick();
      n_cmp++; if (bus.writeReg !== 5'(7 + j) || bus.fifoCount !== 3'(1 - j) || bus.writeEnable !== 1'b1) begin n_err++; $display("FAIL wrap_tail[%0d] got=%0d/%0d exp=%0d/%0d", j, bus.writeReg, bus.fifoCount, 7 + j, 1 - j); end
    end
    tick();
  endtask

  task automatic test_query();
    bus.queryReg = 5'd5;
    #1;
    n_cmp++; if (bus.queryPending !== 1'b0) begin n_err++; $display("FAIL query_idle got=%b exp=0", bus.queryPending); end
    set_wb(1'b1, 3);
    set_md(1'b1, 5);
    tick();
    set_wb(1'b1, 4);
    set_md(1'b1, 0);
    tick();
    drive_idle();
    bus.queryReg = 5'd5;
    #1;
    n_cmp++; if (bus.queryPending !== 1'b1) begin n_err++; $display("FAIL query_buffered got=%b exp=1", bus.queryPending); end
    bus.queryReg = 5'd0;
    #1;
    n_cmp++; if (bus.queryPending !== 1'b0) begin n_err++; $display("FAIL query_zero got=%b exp=0", bus.queryPending); end
    bus.queryReg = 5'd7;
    #1;
    n_cmp++; if (bus.queryPending !== 1'b0) begin n_err++; $display("FAIL query_other got=%b exp=0", bus.queryPending); end
    bus.queryReg = 5'd5;
    tick();
    n_cmp++; if (bus.writeReg !== 5'd5 || bus.queryPending !== 1'b1) begin n_err++; $display("FAIL query_outstage got=%0d/%b exp=5/1", bus.writeReg, bus.queryPending); end
    tick();
    n_cmp++; if (bus.writeEnable !== 1'b1 || bus.writeReg !== 5'd0) begin n_err++; $display("FAIL reg0_pass got=%b/%0d exp=1/0", bus.writeEnable, bus.writeReg); end
    n_cmp++; if (bus.queryPending !== 1'b0) begin n_err++; $display("FAIL query_released got=%b exp=0", bus.queryPending); end
    bus.queryReg = 5'd0;
    #1;
    n_cmp++; if (bus.queryPending !== 1'b0) begin n_err++; $display("FAIL query_zero_out got=%b exp=0", bus.queryPending); end
    tick();
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      set_wb(1'b1, 21 + i);
      set_md(1'b1, 10 + i);
      tick();
    end
    n_cmp++; if (bus.fifoCount !== 3'd3 || bus.writeEnable !== 1'b1) begin n_err++; $display("FAIL mid_pre got=%0d/%b exp=3/1", bus.fifoCount, bus.writeEnable); end
    drive_idle();
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.writeEnable !== 1'b0 || bus.writeReg !== 5'd0) begin n_err++; $display("FAIL mid_rst_we got=%b/%0d exp=0/0", bus.writeEnable, bus.writeReg); end
    n_cmp++; if (bus.writeData !== 32'd0 || bus.PCReg !== 32'd0) begin n_err++; $display("FAIL mid_rst_data got=%h/%h exp=0/0", bus.writeData, bus.PCReg); end
    n_cmp++; if (bus.fifoCount !== 3'd0 || bus.mdReady !== 1'b0 || bus.wbStall !== 1'b0) begin n_err++; $display("FAIL mid_rst_state got=%0d/%b/%b exp=0/0/0", bus.fifoCount, bus.mdReady, bus.wbStall); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus.writeEnable !== 1'b0 || bus.fifoCount !== 3'd0) begin n_err++; $display("FAIL mid_after[%0d] got=%b/%0d exp=0/0", i, bus.writeEnable, bus.fifoCount); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_bypass();
    test_fill_full();
    test_starve();
    test_push_pop_wrap();
    test_query();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
